// File: rtl/gemm_layer_sequencer_if.sv
// Host/config and MAC-array command bundle for gemm_layer_sequencer.
interface gemm_layer_sequencer_if #(
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned WADDR_W    = 16,
  parameter int unsigned AADDR_W    = 8,
  parameter int unsigned BADDR_W    = 8
);
  localparam int unsigned LW    = $clog2(MAX_LAYERS);
  localparam int unsigned CFG_W = WADDR_W + BADDR_W + 2*AADDR_W + 12;

  logic               cfg_we;
  logic [LW-1:0]      cfg_idx;
  logic [CFG_W-1:0]   cfg_data;
  logic [LW:0]        num_layers;
  logic               start;
  logic               abort;
  logic               busy;
  logic               done;
  logic               err;
  logic               issue_valid;
  logic               clear_acc;
  logic [WADDR_W-1:0] weight_addr;
  logic [AADDR_W-1:0] act_in_addr;
  logic               wb_valid;
  logic [AADDR_W-1:0] wb_act_addr;
  logic [BADDR_W-1:0] wb_bias_addr;
  logic [LW-1:0]      layer_idx;

  modport master (
    output cfg_we, cfg_idx, cfg_data, num_layers, start, abort,
    input  busy, done, err, issue_valid, clear_acc, weight_addr, act_in_addr,
           wb_valid, wb_act_addr, wb_bias_addr, layer_idx
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_data, num_layers, start, abort,
    output busy, done, err, issue_valid, clear_acc, weight_addr, act_in_addr,
           wb_valid, wb_act_addr, wb_bias_addr, layer_idx
  );
endinterface

// File: rtl/gemm_layer_sequencer.sv
// Walks a table of layer descriptors and emits one MAC issue command per cycle,
// followed by a writeback strobe per output block.
module gemm_layer_sequencer #(
  parameter int unsigned MAC_COUNT  = 32,
  parameter int unsigned MAX_LAYERS = 8,
  parameter int unsigned WADDR_W    = 16,
  parameter int unsigned AADDR_W    = 8,
  parameter int unsigned BADDR_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  gemm_layer_sequencer_if.slave bus
);
  localparam int unsigned LW    = $clog2(MAX_LAYERS);
  localparam int unsigned NLW   = LW + 1;
  localparam int unsigned CFG_W = WADDR_W + BADDR_W + 2*AADDR_W + 12;

  typedef struct packed {
    logic [WADDR_W-1:0] weight_base;
    logic [BADDR_W-1:0] bias_base;
    logic [AADDR_W-1:0] act_out_base;
    logic [AADDR_W-1:0] act_in_base;
    logic [3:0]         out_blocks;
    logic [7:0]         in_size;
  } desc_t;

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WB, DONE} state_t;

  logic [CFG_W-1:0] table_q [MAX_LAYERS];

  state_t             state_q, state_d;
  logic [7:0]         k_q, k_d;
  logic [3:0]         block_q, block_d;
  logic [LW-1:0]      layer_q, layer_d;
  logic [NLW-1:0]     nl_q, nl_d;
  desc_t              desc_q, desc_d, entry_desc;
  logic               drain_q, drain_d;
  logic               err_q, err_d;
  logic [WADDR_W-1:0] waddr_q, waddr_d;
  logic               enter;

  logic               busy_q, done_q, issue_valid_q, clear_acc_q, wb_valid_q;
  logic [AADDR_W-1:0] act_in_q, act_in_d;
  logic [AADDR_W-1:0] wb_act_q, wb_act_d;
  logic [BADDR_W-1:0] wb_bias_q, wb_bias_d;

  // Table writes are blocked while a sequence is running.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && !busy_q) table_q[bus.cfg_idx] <= bus.cfg_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      k_q           <= '0;
      block_q       <= '0;
      layer_q       <= '0;
      nl_q          <= '0;
      desc_q        <= '0;
      drain_q       <= 1'b0;
      err_q         <= 1'b0;
      waddr_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      issue_valid_q <= 1'b0;
      clear_acc_q   <= 1'b0;
      wb_valid_q    <= 1'b0;
      act_in_q      <= '0;
      wb_act_q      <= '0;
      wb_bias_q     <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      block_q       <= block_d;
      layer_q       <= layer_d;
      nl_q          <= nl_d;
      desc_q        <= desc_d;
      drain_q       <= drain_d;
      err_q         <= err_d;
      waddr_q       <= waddr_d;
      busy_q        <= (state_d == ISSUE) || (state_d == DRAIN) || (state_d == WB);
      done_q        <= (state_d == DONE);
      issue_valid_q <= (state_d == ISSUE);
      clear_acc_q   <= (state_d == ISSUE) && (k_d == 8'd0);
      wb_valid_q    <= (state_d == WB);
      act_in_q      <= act_in_d;
      wb_act_q      <= wb_act_d;
      wb_bias_q     <= wb_bias_d;
    end
  end

  // Next-state and counter update; outputs are registered from the *_d values.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    block_d    = block_q;
    layer_d    = layer_q;
    nl_d       = nl_q;
    desc_d     = desc_q;
    drain_d    = drain_q;
    err_d      = err_q;
    waddr_d    = waddr_q;
    enter      = 1'b0;
    entry_desc = desc_q;
    act_in_d   = act_in_q;
    wb_act_d   = wb_act_q;
    wb_bias_d  = wb_bias_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          err_d   = 1'b0;
          layer_d = '0;
          block_d = '0;
          k_d     = '0;
          nl_d    = bus.num_layers;
          if (bus.num_layers == '0) begin
            state_d = DONE;
          end else begin
            enter = 1'b1;
            // Same-cycle write to slot 0 must be visible to this start.
            entry_desc = (bus.cfg_we && bus.cfg_idx == '0) ? desc_t'(bus.cfg_data)
                                                           : desc_t'(table_q[0]);
          end
        end
      end
      ISSUE: begin
        if (k_q == desc_q.in_size - 8'd1) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          k_d     = k_q + 8'd1;
          waddr_d = waddr_q + WADDR_W'(MAC_COUNT);
        end
      end
      DRAIN: begin
        if (drain_q) state_d = WB;
        else         drain_d = 1'b1;
      end
      WB: begin
        if (block_q < desc_q.out_blocks - 4'd1) begin
          block_d = block_q + 4'd1;
          k_d     = '0;
          state_d = ISSUE;
          waddr_d = waddr_q + WADDR_W'(MAC_COUNT);
        end else if ({1'b0, layer_q} < nl_q - NLW'(1)) begin
          layer_d    = layer_q + LW'(1);
          block_d    = '0;
          k_d        = '0;
          enter      = 1'b1;
          entry_desc = desc_t'(table_q[LW'(layer_q + LW'(1))]);
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Layer entry: reject empty layers, otherwise restart the weight counter.
    if (enter) begin
      desc_d = entry_desc;
      if (entry_desc.in_size == 8'd0 || entry_desc.out_blocks == 4'd0) begin
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        state_d = ISSUE;
        waddr_d = entry_desc.weight_base;
      end
    end

    if (bus.abort && state_q != IDLE) begin
      state_d = IDLE;
      err_d   = err_q;
    end

    if (state_d == ISSUE) act_in_d = desc_d.act_in_base + AADDR_W'(k_d);
    if (state_d == WB) begin
      wb_act_d  = desc_d.act_out_base + AADDR_W'(32'(block_d) * MAC_COUNT);
      wb_bias_d = desc_d.bias_base    + BADDR_W'(32'(block_d) * MAC_COUNT);
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.issue_valid  = issue_valid_q;
  assign bus.clear_acc    = clear_acc_q;
  assign bus.weight_addr  = waddr_q;
  assign bus.act_in_addr  = act_in_q;
  assign bus.wb_valid     = wb_valid_q;
  assign bus.wb_act_addr  = wb_act_q;
  assign bus.wb_bias_addr = wb_bias_q;
  assign bus.layer_idx    = layer_q;
endmodule

// File: tb/tb_gemm_layer_sequencer.sv
// Scoreboard bench: a descriptor-level model predicts every issue/writeback/done event.
module tb_gemm_layer_sequencer;
  localparam int MC = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gemm_layer_sequencer_if #(.MAX_LAYERS(8), .WADDR_W(16), .AADDR_W(8), .BADDR_W(8)) bus ();

  gemm_layer_sequencer #(.MAC_COUNT(MC), .MAX_LAYERS(8), .WADDR_W(16), .AADDR_W(8), .BADDR_W(8))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    int          cyc;
    int          kind;   // 0 issue, 1 writeback, 2 done
    logic        clr;
    logic [15:0] wa;
    logic [7:0]  aa;
    logic [7:0]  ba;
    logic [2:0]  layer;
    logic        errv;
  } ev_t;

  ev_t         q[$];
  logic [51:0] mtab [8];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [51:0] pack(int wb, int bb, int aob, int aib, int ob, int is);
    return {16'(wb), 8'(bb), 8'(aob), 8'(aib), 4'(ob), 8'(is)};
  endfunction

  task automatic push(int c, int kind, logic clr, int wa, int aa, int ba, int layer, logic errv);
    ev_t e;
    e.cyc = c; e.kind = kind; e.clr = clr; e.wa = 16'(wa); e.aa = 8'(aa);
    e.ba = 8'(ba); e.layer = 3'(layer); e.errv = errv;
    q.push_back(e);
  endtask

  // Reference: enumerate the command stream from descriptor fields.
  task automatic gen(int t0, int nl);
    int t;
    logic [51:0] d;
    int is, ob, aib, aob, bb, wb;
    t = t0 + 1;
    for (int l = 0; l < nl; l++) begin
      d   = mtab[l];
      is  = int'(d[7:0]);   ob  = int'(d[11:8]);  aib = int'(d[19:12]);
      aob = int'(d[27:20]); bb  = int'(d[35:28]); wb  = int'(d[51:36]);
      if (is == 0 || ob == 0) begin
        push(t, 2, 1'b0, 0, 0, 0, 0, 1'b1);
        return;
      end
      for (int b = 0; b < ob; b++) begin
        for (int k = 0; k < is; k++) begin
          push(t, 0, k == 0, wb + (b*is + k)*MC, aib + k, 0, l, 1'b0);
          t++;
        end
        t += 2;
        push(t, 1, 1'b0, 0, aob + b*MC, bb + b*MC, l, 1'b0);
        t++;
      end
    end
    push(t, 2, 1'b0, 0, 0, 0, 0, 1'b0);
  endtask

  task automatic truncate(int last);
    while (q.size() != 0 && q[q.size()-1].cyc > last) void'(q.pop_back());
  endtask

  task automatic wr(int idx, logic [51:0] d);
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'(idx); bus.cfg_data = d;
    step();
    bus.cfg_we = 1'b0;
    mtab[idx] = d;
  endtask

  task automatic go(int nl, output int t0);
    t0 = cyc;
    bus.num_layers = 4'(nl);
    bus.start = 1'b1;
    gen(t0, nl);
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 3000) begin step(); n++; end
    check("drain_timeout", 64'(q.size()), 0);
    q.delete();
    repeat (3) step();
  endtask

  task automatic check_reset_vals(string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_err"}, bus.err, 0);
    check({tag, "_issue_valid"}, bus.issue_valid, 0);
    check({tag, "_clear_acc"}, bus.clear_acc, 0);
    check({tag, "_wb_valid"}, bus.wb_valid, 0);
    check({tag, "_weight_addr"}, bus.weight_addr, 0);
    check({tag, "_act_in_addr"}, bus.act_in_addr, 0);
    check({tag, "_wb_act_addr"}, bus.wb_act_addr, 0);
    check({tag, "_wb_bias_addr"}, bus.wb_bias_addr, 0);
    check({tag, "_layer_idx"}, bus.layer_idx, 0);
  endtask

  // Monitor: every strobe cycle must match the head of the expected queue.
  always @(negedge clk) begin
    int n;
    ev_t e;
    if (mon_en) begin
      n = int'(bus.issue_valid) + int'(bus.wb_valid) + int'(bus.done);
      if (n != 0) begin
        check("strobe_count", 64'(n), 1);
        if (q.size() == 0) begin
          check("unexpected_output", 64'(n), 0);
        end else begin
          e = q.pop_front();
          check("event_cycle", 64'(cyc), 64'(e.cyc));
          check("event_kind", bus.issue_valid ? 0 : (bus.wb_valid ? 1 : 2), 64'(e.kind));
          if (e.kind == 0) begin
            check("clear_acc", bus.clear_acc, e.clr);
            check("weight_addr", bus.weight_addr, e.wa);
            check("act_in_addr", bus.act_in_addr, e.aa);
            check("issue_layer", bus.layer_idx, e.layer);
            check("issue_busy", bus.busy, 1);
          end else if (e.kind == 1) begin
            check("wb_act_addr", bus.wb_act_addr, e.aa);
            check("wb_bias_addr", bus.wb_bias_addr, e.ba);
            check("wb_layer", bus.layer_idx, e.layer);
            check("wb_busy", bus.busy, 1);
          end else begin
            check("done_err", bus.err, e.errv);
            check("done_busy", bus.busy, 0);
          end
        end
      end
    end
  end

  initial begin
    int t0;
    int nl;
    int is, ob;
    reset = 1'b1;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_data = '0;
    bus.num_layers = '0; bus.start = 1'b0; bus.abort = 1'b0;
    repeat (3) step();
    check_reset_vals("reset");
    reset = 1'b0;
    step();
    mon_en = 1'b1;

    // Single layer {64,2}.
    wr(0, pack(0, 0, 64, 0, 2, 64));
    go(1, t0);
    wait_done();

    // Two layers {64,2},{64,1}.
    wr(1, pack(16'h1000, 8'h40, 8'h10, 8'h80, 1, 64));
    go(2, t0);
    wait_done();

    // Invalid layer 1; err sticky until the next start.
    wr(1, pack(16'h2000, 0, 0, 0, 1, 0));
    go(2, t0);
    wait_done();
    check("err_sticky", bus.err, 1);
    go(1, t0);
    check("err_cleared_by_start", bus.err, 0);
    wait_done();

    // Abort at the 10th issue cycle, then rerun.
    go(1, t0);
    while (cyc < t0 + 10) step();
    truncate(cyc);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_issue_valid", bus.issue_valid, 0);
    repeat (5) step();
    check("abort_no_events", 64'(q.size()), 0);
    go(1, t0);
    wait_done();

    // Abort while idle has no effect.
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    check("idle_abort_busy", bus.busy, 0);

    // num_layers == 0.
    go(0, t0);
    wait_done();

    // Start during busy is ignored.
    go(1, t0);
    repeat (20) step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done();

    // cfg_we during busy leaves the table alone.
    go(1, t0);
    repeat (5) step();
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'd0; bus.cfg_data = pack(16'h5555, 1, 2, 3, 3, 5);
    step();
    bus.cfg_we = 1'b0;
    wait_done();
    go(1, t0);
    wait_done();

    // Weight address wrap.
    wr(0, pack(16'hFFE0, 8'hF0, 8'hF0, 8'hFE, 2, 2));
    go(1, t0);
    wait_done();

    // Write and start in the same cycle.
    bus.cfg_we = 1'b1; bus.cfg_idx = 3'd0; bus.cfg_data = pack(16'h0300, 8'h11, 8'h22, 8'h33, 2, 3);
    mtab[0] = bus.cfg_data;
    go(1, t0);
    bus.cfg_we = 1'b0;
    wait_done();

    // Reset mid-sequence.
    wr(0, pack(0, 0, 64, 0, 2, 64));
    go(1, t0);
    repeat (7) step();
    truncate(cyc);
    reset = 1'b1;
    step();
    check_reset_vals("midreset");
    reset = 1'b0;
    step();
    check("midreset_no_events", 64'(q.size()), 0);

    // Randomized descriptor tables.
    for (int r = 0; r < 20; r++) begin
      for (int s = 0; s < 8; s++) begin
        is = int'($urandom_range(1, 6));
        ob = int'($urandom_range(1, 3));
        if ($urandom_range(0, 15) == 0) is = 0;
        if ($urandom_range(0, 15) == 0) ob = 0;
        wr(s, pack(int'($urandom), int'($urandom), int'($urandom), int'($urandom), ob, is));
      end
      nl = int'($urandom_range(1, 8));
      go(nl, t0);
      wait_done();
    end

    check("final_queue_empty", 64'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
